lcv_mul_acc_pipe: RTL

Parametrised, three-stage pipelined signed multiply-accumulate unit with valid/ready handshaking on input and output. It computes a running dot-product over a group of beats: the first beat seeds the accumulator with `inp_c + a*b`, and later beats add `a*b`. The last beat of a group emits the result. It is the DSP-mapped arithmetic workhorse for filter and dot-product datapaths, replacing the fixed-width, single-shot multiply-add blocks.

---
 rtl/lcv_mul_acc_pkg.sv | 33 +++
 rtl/lcv_mul_acc_pipe_if.sv | 30 +++
 rtl/lcv_mul_acc_add_sat.sv | 26 ++
 rtl/lcv_mul_acc_pipe.sv | 88 ++++++++
 4 files changed

// File: rtl/lcv_mul_acc_pkg.sv
// Shared types and constant helpers for the pipelined signed multiply-accumulate unit.
package lcv_mul_acc_pkg;

   localparam int MAX_W = 128;

   typedef struct packed {
      logic valid;
      logic first;
      logic last;
   } stage_t;

   function automatic bit acc_width_ok(input int a_w, input int b_w, input int acc_w);
      return (acc_w >= a_w + b_w) && (acc_w <= MAX_W);
   endfunction

   function automatic int prod_width(input int a_w, input int b_w);
      return a_w + b_w;
   endfunction

   // Wide results; callers truncate to their own width, which keeps the two's-complement pattern.
   function automatic logic [MAX_W-1:0] sat_max(input int w);
      logic [MAX_W-1:0] one;
      one = 1;
      return (one << (w - 1)) - one;
   endfunction

   function automatic logic [MAX_W-1:0] sat_min(input int w);
      logic [MAX_W-1:0] one;
      one = 1;
      return ~(one << (w - 1)) + one;
   endfunction

endpackage

// File: rtl/lcv_mul_acc_pipe_if.sv
// Beat input and result output channels of lcv_mul_acc_pipe, both valid/ready.
interface lcv_mul_acc_pipe_if
   import lcv_mul_acc_pkg::*;
#(
   parameter int A_WIDTH   = 16,
   parameter int B_WIDTH   = 16,
   parameter int ACC_WIDTH = 33
);
   logic                        inp_valid;
   logic                        inp_ready;
   logic signed [A_WIDTH-1:0]   inp_a;
   logic signed [B_WIDTH-1:0]   inp_b;
   logic signed [ACC_WIDTH-1:0] inp_c;
   logic                        inp_first;
   logic                        inp_last;
   logic                        outp_valid;
   logic                        outp_ready;
   logic signed [ACC_WIDTH-1:0] outp_data;
   logic                        outp_ovf;

   modport master (
      output inp_valid, inp_a, inp_b, inp_c, inp_first, inp_last, outp_ready,
      input  inp_ready, outp_valid, outp_data, outp_ovf
   );

   modport slave (
      input  inp_valid, inp_a, inp_b, inp_c, inp_first, inp_last, outp_ready,
      output inp_ready, outp_valid, outp_data, outp_ovf
   );
endinterface

// File: rtl/lcv_mul_acc_add_sat.sv
// Combinational signed adder with overflow flag; LCV_MUL_ACC_SAT_EN selects clamping instead of wrap.
module lcv_mul_acc_add_sat
   import lcv_mul_acc_pkg::*;
#(
   parameter int WIDTH = 33
) (
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   output logic signed [WIDTH-1:0] sum,
   output logic                    ovf
);
   logic [WIDTH:0] full;

   assign full = {a[WIDTH-1], a} + {b[WIDTH-1], b};
   assign ovf  = full[WIDTH] ^ full[WIDTH-1];

`ifdef LCV_MUL_ACC_SAT_EN
   localparam logic [WIDTH-1:0] SAT_HI = WIDTH'(sat_max(WIDTH));
   localparam logic [WIDTH-1:0] SAT_LO = WIDTH'(sat_min(WIDTH));

   // The extra top bit carries the true sign, so it picks which rail to clamp to.
   assign sum = ovf ? (full[WIDTH] ? SAT_LO : SAT_HI) : full[WIDTH-1:0];
`else
   assign sum = full[WIDTH-1:0];
`endif
endmodule

// File: rtl/lcv_mul_acc_pipe.sv
// Three-stage pipelined signed multiply-accumulate with a global stall and a registered result.
// Optional clamping of the accumulator is enabled by defining LCV_MUL_ACC_SAT_EN.
module lcv_mul_acc_pipe
   import lcv_mul_acc_pkg::*;
#(
   parameter int A_WIDTH   = 16,
   parameter int B_WIDTH   = 16,
   parameter int ACC_WIDTH = 33
) (
   input logic                 clk,
   input logic                 rst,
   lcv_mul_acc_pipe_if.slave   bus
);
   localparam int P_WIDTH = prod_width(A_WIDTH, B_WIDTH);

   if (!acc_width_ok(A_WIDTH, B_WIDTH, ACC_WIDTH)) begin : g_bad_width
      $error("lcv_mul_acc_pipe: ACC_WIDTH must be at least A_WIDTH + B_WIDTH");
   end

   stage_t                      s0, s1;
   logic signed [A_WIDTH-1:0]   a0;
   logic signed [B_WIDTH-1:0]   b0;
   logic signed [ACC_WIDTH-1:0] c0, c1, prod1, acc, base, step_sum, outp_data;
   logic signed [P_WIDTH-1:0]   prod_full;
   logic                        s2_valid, s2_last, ovf_sticky, step_ovf;
   logic                        outp_valid, outp_ovf, en;

   assign en            = !outp_valid || bus.outp_ready;
   assign bus.inp_ready = en;
   assign bus.outp_valid = outp_valid;
   assign bus.outp_data  = outp_data;
   assign bus.outp_ovf   = outp_ovf;

   assign prod_full = a0 * b0;
   assign base      = s1.first ? c1 : acc;

   lcv_mul_acc_add_sat #(.WIDTH(ACC_WIDTH)) u_add (
      .a   (base),
      .b   (prod1),
      .sum (step_sum),
      .ovf (step_ovf)
   );

   // One enable freezes every stage together, so bubbles stay where they are during a stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         s0         <= '0;
         s1         <= '0;
         a0         <= '0;
         b0         <= '0;
         c0         <= '0;
         c1         <= '0;
         prod1      <= '0;
         s2_valid   <= 1'b0;
         s2_last    <= 1'b0;
         acc        <= '0;
         ovf_sticky <= 1'b0;
         outp_valid <= 1'b0;
         outp_data  <= '0;
         outp_ovf   <= 1'b0;
      end else if (en) begin
         s0.valid <= bus.inp_valid;
         s0.first <= bus.inp_first;
         s0.last  <= bus.inp_last;
         a0       <= bus.inp_a;
         b0       <= bus.inp_b;
         c0       <= bus.inp_c;

         s1    <= s0;
         c1    <= c0;
         prod1 <= ACC_WIDTH'(prod_full);

         s2_valid <= s1.valid;
         s2_last  <= s1.last;
         if (s1.valid) begin
            acc        <= step_sum;
            ovf_sticky <= s1.first ? step_ovf : (ovf_sticky | step_ovf);
         end

         // The result is taken from acc one cycle after the last beat has been folded in.
         outp_valid <= s2_valid && s2_last;
         if (s2_valid && s2_last) begin
            outp_data <= acc;
            outp_ovf  <= ovf_sticky;
         end
      end
   end
endmodule
